// File: rtl/smpl_capture.sv
// smpl_capture: circular sample-RAM capture controller with
// pre-trigger history, post-trigger count and frozen read start.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wrt_smpl, smpl    sample strobe and 8-bit packed word
//   run               capture enable level (0 aborts)
//   triggered         trigger event
//   trig_pos          words to store after the trigger
//   clr_done          host acknowledge of capture_done
//   we, waddr, wdata  registered RAM write port
//   armed             enough history held, trigger accepted
//   capture_done      capture finished, RAM frozen
//   trig_addr         oldest word address when done
module smpl_capture #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic [7:0]        smpl,
  input  logic              run,
  input  logic              triggered,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              clr_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              armed,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam logic [ADDR_W:0] DEPTH_C =
    {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    POST,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_tp;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_pre;
  logic [ADDR_W-1:0]   r_post;

  logic                w_acc;
  logic                w_trig;
  logic                w_post_end;
  logic                w_start;
  logic [ADDR_W-1:0]   w_tp_nxt;
  logic [ADDR_W:0]     w_pre_nxt;
  logic [ADDR_W:0]     w_thresh;

  assign w_post_end = (r_post == r_tp);
  assign w_start    = (r_state == IDLE) & run;

  // trig_pos is only sampled while idle, so
  // mid-capture changes are ignored.
  assign w_tp_nxt = (r_state == IDLE) ?
                    trig_pos : r_tp;

  assign w_thresh = DEPTH_C - {1'b0, w_tp_nxt};

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_trig      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (run) w_state_nxt = CAPT;
      end
      CAPT: begin
        if (!run) begin
          w_state_nxt = IDLE;
        end else begin
          w_acc = wrt_smpl;
          if (armed & triggered) begin
            w_trig      = 1'b1;
            w_state_nxt = POST;
          end
        end
      end
      POST: begin
        if (!run) begin
          w_state_nxt = IDLE;
        end else if (w_post_end) begin
          w_state_nxt = DONE;
        end else begin
          w_acc = wrt_smpl;
        end
      end
      DONE: begin
        if (!run | clr_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // History counter saturates at DEPTH so armed
  // stays true however long the pre-trigger wraps.
  always_comb begin
    w_pre_nxt = r_pre;
    if (r_state == IDLE) begin
      w_pre_nxt = '0;
    end else if ((r_state == CAPT) & w_acc &
                 (r_pre != DEPTH_C)) begin
      w_pre_nxt = r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tp         <= '0;
      r_ptr        <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      trig_addr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tp    <= w_tp_nxt;
      r_pre   <= w_pre_nxt;
      we      <= w_acc;
      // Computed from next-state values so armed
      // rises with the write that satisfies it.
      armed   <= (w_state_nxt == CAPT) &
                 (w_pre_nxt >= w_thresh);
      capture_done <= (w_state_nxt == DONE);

      if (w_start) begin
        r_ptr     <= '0;
        waddr     <= '0;
        trig_addr <= '0;
      end

      if (w_acc) begin
        wdata <= smpl;
        waddr <= r_ptr;
        r_ptr <= r_ptr + 1'b1;
      end

      if (w_trig) begin
        r_post <= '0;
      end else if ((r_state == POST) & w_acc) begin
        r_post <= r_post + 1'b1;
      end

      // Next-write address is the oldest word.
      if ((r_state == POST) &
          (w_state_nxt == DONE)) begin
        trig_addr <= r_ptr;
      end
    end
  end

endmodule

// File: tb/tb_smpl_capture.sv
// tb_smpl_capture: vector table, directed corner cases
// and random traffic against a capture-rule model.
module tb_smpl_capture;

  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wrt_smpl;
  logic [7:0]    smpl;
  logic          run;
  logic          triggered;
  logic [AW-1:0] trig_pos;
  logic          clr_done;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          armed;
  logic          capture_done;
  logic [AW-1:0] trig_addr;

  smpl_capture #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrt_smpl     (wrt_smpl),
    .smpl         (smpl),
    .run          (run),
    .triggered    (triggered),
    .trig_pos     (trig_pos),
    .clr_done     (clr_done),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .armed        (armed),
    .capture_done (capture_done),
    .trig_addr    (trig_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int we_seen = 0;

  // Model: phase 0 idle, 1 history, 2 post, 3 done.
  int m_phase, m_tp, m_written, m_post;
  int m_waddr, m_wdata, m_taddr;
  bit m_we, m_armed, m_done;

  typedef struct {
    int n;
    bit w, r, t, c;
    bit e_we;
    int e_waddr;
    bit e_armed, e_done;
    int e_taddr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tp = 0; m_written = 0;
    m_post = 0; m_waddr = 0; m_wdata = 0;
    m_taddr = 0; m_we = 0; m_armed = 0;
    m_done = 0;
  endtask

  task automatic model_write();
    m_we = 1;
    m_waddr = m_written % D;
    m_wdata = smpl;
    m_written++;
  endtask

  task automatic model_step();
    bit take;
    m_we = 0;
    if (!run) begin
      m_phase = 0;
      m_done = 0;
    end else begin
      case (m_phase)
        0: begin
          m_phase = 1; m_tp = trig_pos;
          m_written = 0; m_waddr = 0;
          m_taddr = 0;
        end
        1: begin
          take = m_armed && triggered;
          if (wrt_smpl) model_write();
          if (take) begin
            m_phase = 2; m_post = 0;
          end
        end
        2: begin
          if (m_post == m_tp) begin
            m_phase = 3; m_done = 1;
            m_taddr = m_written % D;
          end else if (wrt_smpl) begin
            model_write();
            m_post++;
          end
        end
        default: begin
          if (clr_done) begin
            m_phase = 0; m_done = 0;
          end
        end
      endcase
    end
    m_armed = (m_phase == 1) &&
      (((m_written < D) ? m_written : D)
       >= D - m_tp);
  endtask

  task automatic check_all();
    if (we === 1'b1) we_seen++;
    chk("we", we, m_we);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("armed", armed, m_armed);
    chk("done", capture_done, m_done);
    chk("trig_addr", trig_addr, m_taddr);
  endtask

  task automatic cyc(input bit w, input bit r,
                     input bit t, input bit c);
    wrt_smpl = w; run = r;
    triggered = t; clr_done = c;
    smpl = 8'($urandom);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0);
  endtask

  task automatic areset();
    wrt_smpl = 0; triggered = 0; clr_done = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; wrt_smpl = 0; smpl = 0; run = 0;
    triggered = 0; trig_pos = 0; clr_done = 0;
    model_reset();
    #1;
    chk("rst_we", we, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", capture_done, 0);
    check_all();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;

    // Basic capture, trig_pos=4.
    tbl[0] = '{1, 0,1,0,0, 0,  0, 0, 0, 0};
    tbl[1] = '{4, 1,1,0,0, 1,  3, 0, 0, 0};
    tbl[2] = '{1, 1,1,1,0, 1,  4, 0, 0, 0};
    tbl[3] = '{7, 1,1,0,0, 1, 11, 1, 0, 0};
    tbl[4] = '{7, 1,1,0,0, 1,  2, 1, 0, 0};
    tbl[5] = '{1, 1,1,1,0, 1,  3, 0, 0, 0};
    tbl[6] = '{4, 1,1,0,0, 1,  7, 0, 0, 0};
    tbl[7] = '{1, 1,1,0,0, 0,  7, 0, 1, 8};
    tbl[8] = '{3, 1,1,0,0, 0,  7, 0, 1, 8};
    tbl[9] = '{1, 0,1,0,1, 0,  7, 0, 0, 8};
    trig_pos = 4;
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        cyc(tbl[i].w, tbl[i].r,
            tbl[i].t, tbl[i].c);
      chk($sformatf("tbl%0d_we", i),
          we, tbl[i].e_we);
      chk($sformatf("tbl%0d_waddr", i),
          waddr, tbl[i].e_waddr);
      chk($sformatf("tbl%0d_armed", i),
          armed, tbl[i].e_armed);
      chk($sformatf("tbl%0d_done", i),
          capture_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_taddr", i),
          trig_addr, tbl[i].e_taddr);
    end
    chk("tbl_we_count", we_seen, 24);

    // Wrap with 40 history words.
    we_seen = 0;
    cyc(0, 1, 0, 0);
    strobes(16);
    chk("wrap_15", waddr, 15);
    strobes(1);
    chk("wrap_0", waddr, 0);
    strobes(23);
    chk("wrap_40", waddr, 7);
    chk("wrap_sat_armed", armed, 1);
    cyc(0, 1, 1, 0);
    chk("wrap_trig_we", we, 0);
    strobes(5);
    chk("wrap_done", capture_done, 1);
    chk("wrap_taddr", trig_addr, 12);
    chk("wrap_we_count", we_seen, 44);
    cyc(0, 0, 0, 0);

    // trig_pos=0.
    trig_pos = 0;
    we_seen = 0;
    cyc(0, 1, 0, 0);
    strobes(15);
    chk("tp0_armed15", armed, 0);
    strobes(1);
    chk("tp0_armed16", armed, 1);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    chk("tp0_done", capture_done, 1);
    chk("tp0_we", we, 0);
    chk("tp0_taddr", trig_addr, 0);
    cyc(1, 1, 0, 0);
    chk("tp0_we_count", we_seen, 16);
    cyc(0, 0, 0, 0);
    chk("tp0_abort_done", capture_done, 0);

    // Strobe and trigger together, trig_pos=2.
    trig_pos = 2;
    we_seen = 0;
    cyc(0, 1, 0, 0);
    strobes(13);
    chk("sim_armed13", armed, 0);
    strobes(1);
    chk("sim_armed14", armed, 1);
    cyc(1, 1, 1, 0);
    trig_pos = 9;
    chk("sim_trig_we", we, 1);
    chk("sim_trig_waddr", waddr, 14);
    strobes(2);
    chk("sim_post_waddr", waddr, 0);
    strobes(1);
    chk("sim_done", capture_done, 1);
    chk("sim_taddr", trig_addr, 1);
    strobes(3);
    chk("sim_we_count", we_seen, 17);
    cyc(0, 1, 0, 1);
    chk("sim_clr", capture_done, 0);

    // Abort from POST.
    trig_pos = 15;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("ab_armed", armed, 1);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("ab_we", we, 0);
    chk("ab_done", capture_done, 0);
    cyc(1, 0, 0, 0);

    // Async reset in POST, CAPT and DONE.
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    chk("rp_we_before", we, 1);
    areset();
    chk("rp_we", we, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    areset();
    chk("rc_armed", armed, 0);
    trig_pos = 0;
    cyc(0, 1, 0, 0);
    strobes(16);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    chk("rd_done_before", capture_done, 1);
    areset();
    chk("rd_done", capture_done, 0);
    we_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
    chk("rel_idle_we", we_seen, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0)
        trig_pos = AW'($urandom);
      cyc($urandom_range(0, 1) == 1,
          $urandom_range(0, 99) != 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
